sub8_serial: RTL and testbench
==============================

// Module: sub8_serial
// PURPOSE
//  Bit-serial, LSB-first subtractor: computes D = A - B over WIDTH clock cycles
//  using a single full-adder slice and a registered carry (A + ~B + 1).
//  Sequential counterpart to the parallel adder8 datapath; used where area
//  matters more than latency. Start/busy/done handshake toward the controller.
// PARAMETERS
//  WIDTH     8     operand and result width in bits (>= 2)
// PORTS
//  i_clk     in   1      clock; all state updates on rising edge
//  i_rst_n   in   1      reset, synchronous, active-low
//  i_start   in   1      request; sampled only in IDLE or DONE
//  i_A       in   WIDTH  minuend; captured on the accepted i_start cycle
//  i_B       in   WIDTH  subtrahend; captured on the accepted i_start cycle
//  o_busy    out  1      high while in SHIFT
//  o_done    out  1      one-cycle pulse when the result becomes valid
//  o_D       out  WIDTH  difference A - B mod 2^WIDTH
//  o_Bout    out  1      unsigned borrow: 1 iff A < B
//  o_V       out  1      signed (two's complement) overflow
//  o_Z       out  1      1 iff o_D == 0
// BEHAVIOUR
//  Reset (i_rst_n low at a rising edge): state=IDLE; o_busy=0, o_done=0,
//   o_D=0, o_Bout=0, o_V=0, o_Z=0; shift registers and bit counter cleared.
//   Reset has priority over everything, including mid-SHIFT; partial result dropped.
//  FSM: IDLE -> SHIFT on i_start=1; SHIFT -> DONE after WIDTH bit cycles;
//   DONE -> SHIFT if i_start=1 else DONE -> IDLE. DONE lasts exactly one cycle.
//  Accept (edge 0): latch i_A, ~i_B into shift regs, carry<=1, count<=0,
//   o_busy<=1. Outputs o_D/flags keep previous values until DONE.
//  SHIFT (edges 1..WIDTH): sum=a0^b0^c; carry<=maj(a0,b0,c); sum shifted in
//   at result MSB, operand regs shift right; count increments.
//   On edge WIDTH the last bit is processed and state<=DONE.
//  DONE (edge WIDTH+1): o_D<=result reg, o_Bout<=~carry, o_V<=carry into MSB
//   XOR carry out of MSB, o_Z<=(result==0); o_done=1 for this cycle only;
//   o_busy<=0. Latency: accepted i_start to o_done = WIDTH+1 cycles (9 default).
//  Results and flags hold stable until the next DONE or reset.
//  i_start while in SHIFT: ignored, no effect on operands or count.
//  i_start in DONE cycle: accepted; new operands latched; back-to-back
//   throughput one result per WIDTH+1 cycles; o_done still pulses.
//  i_A/i_B changes after acceptance have no effect on the running operation.
//  o_busy and o_done are never high in the same cycle.
// TESTING
//  1 A=8'h07,B=8'hFB, start pulse -> o_done exactly 9 cycles later;
//    o_D=8'h0C, o_Bout=1, o_V=0, o_Z=0; o_busy high for 8 cycles.
//  2 A=8'h80,B=8'h01 -> o_D=8'h7F, o_Bout=0, o_V=1, o_Z=0.
//  3 A=8'h55,B=8'h55 -> o_D=8'h00, o_Bout=0, o_V=0, o_Z=1;
//    then A=8'h00,B=8'h01 -> o_D=8'hFF, o_Bout=1, o_V=0.
//  4 start with A=8'h10,B=8'h03; at cycle 3 pulse i_start with A=8'hFF,B=8'hFF
//    and change inputs -> single result o_D=8'h0D, exactly one o_done.
//  5 i_start held high continuously, operands updated each DONE -> o_done every
//    9 cycles, each result matches operands latched at its accept edge.
//  6 i_rst_n low at cycle 4 of SHIFT -> next cycle all outputs 0, state IDLE,
//    no o_done; a fresh start afterwards computes correctly.

Source files
------------

// File: rtl/sub8_serial.sv
// Bit-serial LSB-first subtractor: D = A + ~B + 1 using one full-adder slice,
// one bit per clock, with a start/busy/done handshake toward the controller.
module sub8_serial #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_A,
   input  logic [WIDTH-1:0] i_B,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_D,
   output logic             o_Bout,
   output logic             o_V,
   output logic             o_Z
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_d;
   logic             r_bout;
   logic             r_v;
   logic             r_z;

   logic             w_accept;
   logic             w_last;
   logic             w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_result;

   // The minuend register doubles as the result register: sum bits enter at the
   // MSB as operand bits leave at the LSB, so after WIDTH shifts it holds D.
   assign w_sum    = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_cout   = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
   assign w_result = {w_sum, r_a[WIDTH-1:1]};
   assign w_accept = i_start && (r_state != S_SHIFT);
   assign w_last   = (r_state == S_SHIFT) && (r_count == LAST_BIT);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_next = S_SHIFT;
         S_SHIFT: if (w_last)  w_state_next = S_DONE;
         S_DONE:  w_state_next = i_start ? S_SHIFT : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_count <= '0;
         r_d     <= '0;
         r_bout  <= 1'b0;
         r_v     <= 1'b0;
         r_z     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_a     <= i_A;
            r_b     <= ~i_B;
            r_carry <= 1'b1;
            r_count <= '0;
         end else if (r_state == S_SHIFT) begin
            r_a     <= w_result;
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_carry <= w_cout;
            r_count <= r_count + CW'(1);
         end
         // Results are captured with the last bit so they are valid during DONE.
         if (w_last) begin
            r_d    <= w_result;
            r_bout <= ~w_cout;
            r_v    <= r_carry ^ w_cout;
            r_z    <= (w_result == '0);
         end
      end
   end

   assign o_busy = (r_state == S_SHIFT);
   assign o_done = (r_state == S_DONE);
   assign o_D    = r_d;
   assign o_Bout = r_bout;
   assign o_V    = r_v;
   assign o_Z    = r_z;

endmodule

// File: tb/tb_sub8_serial.sv
// Randomized self-checking bench for sub8_serial against an arithmetic model
// of A - B with unsigned borrow, signed overflow and zero flags.
module tb_sub8_serial;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_start = 1'b0;
   logic [7:0] i_A = 8'h00;
   logic [7:0] i_B = 8'h00;
   logic       o_busy, o_done, o_Bout, o_V, o_Z;
   logic [7:0] o_D;

   int n_pass = 0;
   int n_total = 0;

   sub8_serial #(.WIDTH(8)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
      .i_A(i_A), .i_B(i_B),
      .o_busy(o_busy), .o_done(o_done), .o_D(o_D),
      .o_Bout(o_Bout), .o_V(o_V), .o_Z(o_Z)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Reference: plain integer arithmetic, packed as {D, Bout, V, Z}.
   function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b);
      int ua, ub, sa, sb, sd;
      logic [7:0] d;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      sd = sa - sb;
      d  = 8'((ua - ub + 256) % 256);
      return {d, (ua < ub), (sd > 127 || sd < -128), (d == 8'h00)};
   endfunction

   // Stimulus only: one operation, watched for 14 cycles after acceptance.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int poke_k,
                         output int lat, output int busy_c, output int done_c,
                         output int overlap);
      i_A = a; i_B = b; i_start = 1'b1;
      tick();
      lat = -1; busy_c = 0; done_c = 0; overlap = 0;
      for (int k = 0; k < 14; k++) begin
         if (o_busy) busy_c++;
         if (o_done) begin
            done_c++;
            if (lat < 0) lat = k + 1;
         end
         if (o_busy && o_done) overlap++;
         if (k == poke_k) begin
            i_start = 1'b1; i_A = 8'hFF; i_B = 8'hFF;
         end else begin
            i_start = 1'b0; i_A = 8'($urandom); i_B = 8'($urandom);
         end
         tick();
      end
      $display("op A=%02h B=%02h -> D=%02h Bout=%0b V=%0b Z=%0b lat=%0d busy=%0d done=%0d",
               a, b, o_D, o_Bout, o_V, o_Z, lat, busy_c, done_c);
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_start = 1'b1; i_A = 8'h12; i_B = 8'h34;
      tick(); tick();
      n_total++;
      if ({o_busy, o_done, o_D, o_Bout, o_V, o_Z} !== 13'h0) begin
         $display("FAIL reset_outputs: got busy=%0b done=%0b D=%02h B=%0b V=%0b Z=%0b, want all 0",
                  o_busy, o_done, o_D, o_Bout, o_V, o_Z);
      end else n_pass++;
      i_start = 1'b0; i_rst_n = 1'b1;
      tick();
      $display("reset applied and released");
   endtask

   task automatic test_directed();
      logic [7:0] va[4] = '{8'h07, 8'h80, 8'h55, 8'h00};
      logic [7:0] vb[4] = '{8'hFB, 8'h01, 8'h55, 8'h01};
      logic [10:0] exp_v;
      int lat, busy_c, done_c, overlap;
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], -1, lat, busy_c, done_c, overlap);
         exp_v = model(va[i], vb[i]);
         n_total++;
         if ({o_D, o_Bout, o_V, o_Z} !== exp_v) begin
            $display("FAIL directed_result[%0d]: got D=%02h B=%0b V=%0b Z=%0b, want D=%02h B=%0b V=%0b Z=%0b",
                     i, o_D, o_Bout, o_V, o_Z, exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
         end else n_pass++;
         n_total++;
         if (lat != 9 || done_c != 1) begin
            $display("FAIL directed_latency[%0d]: got lat=%0d pulses=%0d, want lat=9 pulses=1",
                     i, lat, done_c);
         end else n_pass++;
         n_total++;
         if (busy_c != 8 || overlap != 0) begin
            $display("FAIL directed_busy[%0d]: got busy=%0d overlap=%0d, want busy=8 overlap=0",
                     i, busy_c, overlap);
         end else n_pass++;
      end
   endtask

   task automatic test_ignore_start();
      int lat, busy_c, done_c, overlap;
      run_op(8'h10, 8'h03, 2, lat, busy_c, done_c, overlap);
      n_total++;
      if (o_D !== 8'h0D || done_c != 1) begin
         $display("FAIL ignore_start: got D=%02h pulses=%0d, want D=0d pulses=1", o_D, done_c);
      end else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] qa[$];
      logic [7:0] qb[$];
      logic [7:0] a, b;
      logic [10:0] exp_v;
      int results = 0;
      int last_done = -1;
      a = 8'($urandom); b = 8'($urandom);
      qa.push_back(a); qb.push_back(b);
      i_A = a; i_B = b; i_start = 1'b1;
      tick();
      for (int cyc = 0; cyc < 60 && results < 4; cyc++) begin
         if (o_done) begin
            a = qa.pop_front(); b = qb.pop_front();
            exp_v = model(a, b);
            $display("b2b A=%02h B=%02h -> D=%02h at cycle %0d", a, b, o_D, cyc);
            n_total++;
            if ({o_D, o_Bout, o_V, o_Z} !== exp_v || o_busy !== 1'b0) begin
               $display("FAIL b2b_result[%0d]: got D=%02h flags=%03b busy=%0b, want D=%02h flags=%03b busy=0",
                        results, o_D, {o_Bout, o_V, o_Z}, o_busy, exp_v[10:3], exp_v[2:0]);
            end else n_pass++;
            if (last_done >= 0) begin
               n_total++;
               if (cyc - last_done != 9) begin
                  $display("FAIL b2b_interval[%0d]: got %0d cycles, want 9", results, cyc - last_done);
               end else n_pass++;
            end
            last_done = cyc;
            results++;
            if (results < 4) begin
               a = 8'($urandom); b = 8'($urandom);
               qa.push_back(a); qb.push_back(b);
               i_A = a; i_B = b;
            end else i_start = 1'b0;
         end else begin
            i_A = 8'($urandom); i_B = 8'($urandom);
         end
         tick();
      end
      i_start = 1'b0;
      n_total++;
      if (results != 4) begin
         $display("FAIL b2b_count: got %0d results, want 4", results);
      end else n_pass++;
      repeat (12) tick();
   endtask

   task automatic test_reset_mid();
      int lat, busy_c, done_c, overlap;
      int pulses = 0;
      run_op(8'h33, 8'h11, -1, lat, busy_c, done_c, overlap);
      i_A = 8'h40; i_B = 8'h90; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (3) tick();
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      n_total++;
      if ({o_busy, o_done, o_D, o_Bout, o_V, o_Z} !== 13'h0) begin
         $display("FAIL midreset_outputs: got busy=%0b done=%0b D=%02h B=%0b V=%0b Z=%0b, want all 0",
                  o_busy, o_done, o_D, o_Bout, o_V, o_Z);
      end else n_pass++;
      for (int k = 0; k < 12; k++) begin
         if (o_done || o_busy) pulses++;
         tick();
      end
      n_total++;
      if (pulses != 0) begin
         $display("FAIL midreset_quiet: got %0d active cycles, want 0", pulses);
      end else n_pass++;
      $display("mid-shift reset dropped A=40 B=90");
      run_op(8'h40, 8'h90, -1, lat, busy_c, done_c, overlap);
      n_total++;
      if ({o_D, o_Bout, o_V, o_Z} !== model(8'h40, 8'h90) || done_c != 1) begin
         $display("FAIL midreset_fresh: got D=%02h flags=%03b pulses=%0d, want D=b0 flags=110 pulses=1",
                  o_D, {o_Bout, o_V, o_Z}, done_c);
      end else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0] ea[4] = '{8'h7F, 8'h80, 8'hFF, 8'h00};
      logic [7:0] eb[4] = '{8'h80, 8'h7F, 8'hFF, 8'hFF};
      logic [7:0] a, b;
      logic [10:0] exp_v;
      int lat, busy_c, done_c, overlap;
      for (int i = 0; i < 24; i++) begin
         if (i < 4) begin
            a = ea[i]; b = eb[i];
         end else begin
            a = 8'($urandom); b = (i % 5 == 0) ? a : 8'($urandom);
         end
         run_op(a, b, -1, lat, busy_c, done_c, overlap);
         exp_v = model(a, b);
         n_total++;
         if ({o_D, o_Bout, o_V, o_Z} !== exp_v || lat != 9 || overlap != 0) begin
            $display("FAIL random[%0d] A=%02h B=%02h: got D=%02h flags=%03b lat=%0d, want D=%02h flags=%03b lat=9",
                     i, a, b, o_D, {o_Bout, o_V, o_Z}, lat, exp_v[10:3], exp_v[2:0]);
         end else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
